// File: rtl/sdram_port_scheduler_if.sv
// sdram_port_scheduler_if: controller-side and requester-side buses of the SDRAM port scheduler.
interface sdram_port_scheduler_if;
  logic        sdram_cmd_valid, sdram_cmd_ready;
  logic        sdram_rd, sdram_wr, sdram_burst;
  logic [23:0] sdram_addr_x16;
  logic [15:0] sdram_wdata;
  logic [1:0]  sdram_wmask;
  logic        sdram_resp_valid;
  logic [15:0] sdram_rdata;
  logic        sdram_rdy, sdram_ack;
  logic [15:0] rdata_o;
  logic        vid_cmd_valid, vid_ack;
  logic [23:0] vid_addr_x16;
  logic        vid_cmd_ready, vid_rdy, vid_resp_valid;
  logic        cpu_cmd_valid, cpu_wr, cpu_ack;
  logic [23:0] cpu_addr_x16;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_wmask;
  logic        cpu_cmd_ready, cpu_rdy, cpu_resp_valid;
  logic        dma_cmd_valid, dma_wr, dma_burst, dma_ack;
  logic [23:0] dma_addr_x16;
  logic [15:0] dma_wdata;
  logic [1:0]  dma_wmask;
  logic        dma_cmd_ready, dma_rdy, dma_resp_valid;
  modport master (
    input  sdram_cmd_ready, sdram_resp_valid, sdram_rdata, sdram_rdy,
    input  vid_cmd_valid, vid_ack, vid_addr_x16,
    input  cpu_cmd_valid, cpu_wr, cpu_ack, cpu_addr_x16, cpu_wdata, cpu_wmask,
    input  dma_cmd_valid, dma_wr, dma_burst, dma_ack, dma_addr_x16, dma_wdata, dma_wmask,
    output sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_ack, rdata_o,
    output vid_cmd_ready, vid_rdy, vid_resp_valid,
    output cpu_cmd_ready, cpu_rdy, cpu_resp_valid,
    output dma_cmd_ready, dma_rdy, dma_resp_valid
  );
  modport slave (
    output sdram_cmd_ready, sdram_resp_valid, sdram_rdata, sdram_rdy,
    output vid_cmd_valid, vid_ack, vid_addr_x16,
    output cpu_cmd_valid, cpu_wr, cpu_ack, cpu_addr_x16, cpu_wdata, cpu_wmask,
    output dma_cmd_valid, dma_wr, dma_burst, dma_ack, dma_addr_x16, dma_wdata, dma_wmask,
    input  sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_ack, rdata_o,
    input  vid_cmd_ready, vid_rdy, vid_resp_valid,
    input  cpu_cmd_ready, cpu_rdy, cpu_resp_valid,
    input  dma_cmd_ready, dma_rdy, dma_resp_valid
  );
endinterface

// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: video-priority, CPU/DMA round-robin owner arbitration for one SDRAM controller.
module sdram_port_scheduler #(
  parameter int MAX_VID_RUN = 4,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk_i,
  input logic rst_ni,
  sdram_port_scheduler_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {NONE, VID, CPU, DMA} owner_t;
  state_t state, state_nx;
  owner_t owner, sel, cur;
  logic rr_dma, others_pend, accept, owner_ack, busy, rdy_ok;
  logic [3:0] vid_run;
  logic [1:0] wait_cnt;
  always_comb begin
    busy = state == BUSY;
    others_pend = bus.cpu_cmd_valid | bus.dma_cmd_valid;
    sel = NONE;
    if (rst_ni && !busy) begin
      if (bus.vid_cmd_valid && (!others_pend || vid_run < 4'(MAX_VID_RUN))) sel = VID;
      else if (rr_dma) sel = bus.cpu_cmd_valid ? CPU : bus.dma_cmd_valid ? DMA : NONE;
      else sel = bus.dma_cmd_valid ? DMA : bus.cpu_cmd_valid ? CPU : NONE;
    end
    cur = busy ? owner : sel;
    bus.sdram_cmd_valid = sel != NONE;
    accept = (sel != NONE) & bus.sdram_cmd_ready;
    bus.sdram_rd = cur == VID | (cur == CPU & !bus.cpu_wr) | (cur == DMA & !bus.dma_wr);
    bus.sdram_wr = (cur == CPU & bus.cpu_wr) | (cur == DMA & bus.dma_wr);
    bus.sdram_burst = cur == VID | (cur == DMA & bus.dma_burst);
    bus.sdram_addr_x16 = cur == VID ? bus.vid_addr_x16 : cur == DMA ? bus.dma_addr_x16 : bus.cpu_addr_x16;
    bus.sdram_wdata = cur == DMA ? bus.dma_wdata : bus.cpu_wdata;
    bus.sdram_wmask = cur == DMA ? bus.dma_wmask : bus.cpu_wmask;
    bus.vid_cmd_ready = sel == VID & bus.sdram_cmd_ready;
    bus.cpu_cmd_ready = sel == CPU & bus.sdram_cmd_ready;
    bus.dma_cmd_ready = sel == DMA & bus.sdram_cmd_ready;
    rdy_ok = busy & bus.sdram_rdy & wait_cnt == 2'd0;
    bus.vid_rdy = rdy_ok & owner == VID;
    bus.cpu_rdy = rdy_ok & owner == CPU;
    bus.dma_rdy = rdy_ok & owner == DMA;
    bus.vid_resp_valid = busy & owner == VID & bus.sdram_resp_valid;
    bus.cpu_resp_valid = busy & owner == CPU & bus.sdram_resp_valid;
    bus.dma_resp_valid = busy & owner == DMA & bus.sdram_resp_valid;
    owner_ack = owner == VID ? bus.vid_ack : owner == CPU ? bus.cpu_ack : owner == DMA ? bus.dma_ack : 1'b0;
    bus.sdram_ack = busy & owner_ack;
    bus.rdata_o = bus.sdram_rdata;
    state_nx = accept ? BUSY : (busy & owner_ack) ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= NONE;
      rr_dma <= 1'b1;
      vid_run <= 4'd0;
      wait_cnt <= 2'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= sel;
        wait_cnt <= 2'(WAIT_CYCLES);
        // the run only counts while someone else is waiting
        if (sel == VID) vid_run <= others_pend ? vid_run + 4'(vid_run != 4'd15) : 4'd0;
        else begin
          vid_run <= 4'd0;
          rr_dma <= sel == DMA;
        end
      end else if (busy) begin
        if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
        if (owner_ack) owner <= NONE;
      end else if (!others_pend) vid_run <= 4'd0;
    end
  end
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// tb_sdram_port_scheduler: directed checks of arbitration order, wait masking, routing and reset.
module tb_sdram_port_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  sdram_port_scheduler_if bus ();
  sdram_port_scheduler dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] strobes();
    return {bus.sdram_cmd_valid, bus.sdram_ack, bus.vid_cmd_ready, bus.vid_rdy, bus.vid_resp_valid,
            bus.cpu_cmd_ready, bus.cpu_rdy, bus.cpu_resp_valid, bus.dma_cmd_ready, bus.dma_rdy, bus.dma_resp_valid};
  endfunction
  // one full transaction: grant, then the granted requester releases on the next cycle
  task automatic txn(input int exp, input string tag);
    int who;
    @(negedge clk);
    bus.sdram_cmd_ready = 1'b1;
    #1;
    who = bus.vid_cmd_ready ? 1 : bus.cpu_cmd_ready ? 2 : bus.dma_cmd_ready ? 3 : 0;
    chk(tag, who, exp);
    @(negedge clk);
    bus.sdram_cmd_ready = 1'b0;
    bus.vid_ack = who == 1;
    bus.cpu_ack = who == 2;
    bus.dma_ack = who == 3;
    @(negedge clk);
    {bus.vid_ack, bus.cpu_ack, bus.dma_ack} = 3'b000;
  endtask
  initial begin
    {bus.sdram_cmd_ready, bus.sdram_resp_valid, bus.sdram_rdy} = 3'b000;
    bus.sdram_rdata = 16'h0;
    {bus.vid_cmd_valid, bus.vid_ack} = 2'b00;
    bus.vid_addr_x16 = 24'h0;
    {bus.cpu_cmd_valid, bus.cpu_wr, bus.cpu_ack} = 3'b000;
    bus.cpu_addr_x16 = 24'h0;
    bus.cpu_wdata = 16'h0;
    bus.cpu_wmask = 2'b00;
    {bus.dma_cmd_valid, bus.dma_wr, bus.dma_burst, bus.dma_ack} = 4'b0000;
    bus.dma_addr_x16 = 24'h0;
    bus.dma_wdata = 16'h0;
    bus.dma_wmask = 2'b00;
    #2;
    chk("reset_strobes", 32'(strobes()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_strobes", 32'(strobes()), 32'h0);
    @(negedge clk);
    bus.cpu_cmd_valid = 1'b1;
    bus.cpu_addr_x16 = 24'h000100;
    bus.sdram_cmd_ready = 1'b1;
    #1;
    chk("cpu_cmd_valid", 32'(bus.sdram_cmd_valid), 32'h1);
    chk("cpu_rd", 32'({bus.sdram_rd, bus.sdram_wr, bus.sdram_burst}), 32'h4);
    chk("cpu_addr", 32'(bus.sdram_addr_x16), 32'h000100);
    chk("cpu_cmd_ready", 32'(bus.cpu_cmd_ready), 32'h1);
    @(negedge clk);
    bus.cpu_cmd_valid = 1'b0;
    bus.sdram_cmd_ready = 1'b0;
    bus.sdram_rdy = 1'b1;
    #1;
    chk("busy_no_cmd", 32'(bus.sdram_cmd_valid), 32'h0);
    chk("cpu_rdy_mask1", 32'(bus.cpu_rdy), 32'h0);
    @(negedge clk);
    #1;
    chk("cpu_rdy_mask2", 32'(bus.cpu_rdy), 32'h0);
    @(negedge clk);
    #1;
    chk("cpu_rdy_open", 32'(bus.cpu_rdy), 32'h1);
    @(negedge clk);
    bus.sdram_rdy = 1'b0;
    bus.cpu_ack = 1'b1;
    bus.cpu_cmd_valid = 1'b1;
    bus.sdram_cmd_ready = 1'b1;
    #1;
    chk("cpu_ack_fwd", 32'(bus.sdram_ack), 32'h1);
    chk("bubble_ready", 32'(bus.cpu_cmd_ready), 32'h0);
    @(negedge clk);
    bus.cpu_ack = 1'b0;
    #1;
    chk("after_bubble_ready", 32'(bus.cpu_cmd_ready), 32'h1);
    chk("idle_ack", 32'(bus.sdram_ack), 32'h0);
    bus.cpu_cmd_valid = 1'b0;
    bus.sdram_cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_again", 32'(strobes()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cpu_cmd_valid = 1'b1;
    bus.dma_cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) txn(i % 2 == 0 ? 2 : 3, $sformatf("rr_%0d", i));
    bus.dma_cmd_valid = 1'b0;
    bus.vid_cmd_valid = 1'b1;
    bus.vid_addr_x16 = 24'h00ABCD;
    for (int i = 0; i < 10; i++) txn(i % 5 == 4 ? 2 : 1, $sformatf("vid_run_%0d", i));
    bus.cpu_cmd_valid = 1'b0;
    bus.dma_cmd_valid = 1'b1;
    bus.dma_wr = 1'b1;
    bus.dma_wmask = 2'b01;
    bus.dma_wdata = 16'hA5A5;
    bus.dma_addr_x16 = 24'h123456;
    txn(1, "vid_before_dma");
    @(negedge clk);
    bus.vid_cmd_valid = 1'b0;
    #1;
    chk("dma_wr_type", 32'({bus.sdram_rd, bus.sdram_wr, bus.sdram_burst}), 32'h2);
    chk("dma_wdata", 32'(bus.sdram_wdata), 32'hA5A5);
    chk("dma_wmask", 32'(bus.sdram_wmask), 32'h1);
    chk("dma_addr", 32'(bus.sdram_addr_x16), 32'h123456);
    txn(3, "dma_after_vid");
    bus.dma_cmd_valid = 1'b0;
    bus.dma_wr = 1'b0;
    @(negedge clk);
    bus.vid_cmd_valid = 1'b1;
    bus.sdram_cmd_ready = 1'b1;
    #1;
    chk("vid_type", 32'({bus.sdram_rd, bus.sdram_wr, bus.sdram_burst}), 32'h5);
    chk("vid_addr", 32'(bus.sdram_addr_x16), 32'h00ABCD);
    @(negedge clk);
    bus.vid_cmd_valid = 1'b0;
    bus.sdram_cmd_ready = 1'b0;
    bus.sdram_resp_valid = 1'b1;
    bus.sdram_rdata = 16'h1234;
    bus.cpu_ack = 1'b1;
    #1;
    chk("vid_resp", 32'(bus.vid_resp_valid), 32'h1);
    chk("rdata_bcast", 32'(bus.rdata_o), 32'h1234);
    chk("others_resp", 32'({bus.cpu_resp_valid, bus.dma_resp_valid}), 32'h0);
    chk("nonowner_ack", 32'(bus.sdram_ack), 32'h0);
    @(negedge clk);
    bus.sdram_resp_valid = 1'b0;
    bus.cpu_ack = 1'b0;
    bus.vid_ack = 1'b1;
    #1;
    chk("vid_ack_fwd", 32'(bus.sdram_ack), 32'h1);
    @(negedge clk);
    bus.vid_ack = 1'b0;
    @(negedge clk);
    bus.dma_cmd_valid = 1'b1;
    bus.dma_burst = 1'b1;
    bus.sdram_cmd_ready = 1'b1;
    @(negedge clk);
    bus.sdram_cmd_ready = 1'b0;
    bus.sdram_resp_valid = 1'b1;
    bus.cpu_cmd_valid = 1'b1;
    #1;
    chk("dma_resp", 32'(bus.dma_resp_valid), 32'h1);
    chk("dma_burst", 32'(bus.sdram_burst), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", 32'(strobes()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sdram_resp_valid = 1'b0;
    txn(2, "post_reset_tie");
    bus.cpu_cmd_valid = 1'b0;
    bus.dma_cmd_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
